// File: rtl/keccak_pad_pkg.sv
// Shared constants, state encoding and mode tables for the Keccak
// message padder.
package keccak_pad_pkg;

  localparam int CNT_W = 5;

  localparam logic [7:0] DOMAIN_SHA3  = 8'h06;
  localparam logic [7:0] DOMAIN_SHAKE = 8'h1F;
  localparam logic [7:0] PAD_END      = 8'h80;

  typedef enum logic [1:0] {
    IDLE,
    ABSORB,
    PAD,
    FILL
  } state_e;

  // Rate in 64-bit lanes; unused codes fall back to SHA3-256.
  function automatic logic [CNT_W-1:0] rate_lanes(
    input logic [2:0] cmode
  );
    logic [CNT_W-1:0] r;
    case (cmode)
      3'd0:    r = 5'd18;
      3'd1:    r = 5'd17;
      3'd2:    r = 5'd13;
      3'd3:    r = 5'd9;
      3'd4:    r = 5'd21;
      3'd5:    r = 5'd17;
      default: r = 5'd17;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] domain_byte(
    input logic [2:0] cmode
  );
    logic [7:0] d;
    if (cmode == 3'd4 || cmode == 3'd5) begin
      d = DOMAIN_SHAKE;
    end else begin
      d = DOMAIN_SHA3;
    end
    return d;
  endfunction

endpackage

// File: rtl/lane_packer.sv
// Merges a half-lane buffer and an incoming word into a 64-bit lane and
// builds the padded tail lane with the domain byte at the next free byte.
module lane_packer (
  input  logic [31:0] lo_i,
  input  logic [31:0] word_i,
  input  logic [2:0]  bytes_i,
  input  logic        hi_i,
  input  logic [7:0]  dom_i,
  output logic [63:0] lane_o,
  output logic [63:0] pad_o,
  output logic        full_o
);

  logic [2:0]  tail;
  logic [3:0]  nb;
  logic [63:0] raw;
  logic [63:0] mask;
  logic [63:0] dom_sh;

  always_comb begin
    tail = (bytes_i > 3'd4) ? 3'd4 : bytes_i;
    nb   = hi_i ? (4'd4 + {1'b0, tail}) : {1'b0, tail};
    raw  = hi_i ? {word_i, lo_i} : {32'h0, word_i};
    mask = '0;
    for (int i = 0; i < 8; i++) begin
      mask[i*8 +: 8] = (4'(i) < nb) ? 8'hFF : 8'h00;
    end
    full_o = (nb == 4'd8);
    dom_sh = {56'h0, dom_i} << {nb[2:0], 3'b000};
    // A full tail lane pushes the domain byte into a fresh lane.
    if (full_o) begin
      pad_o = {56'h0, dom_i};
    end else begin
      pad_o = (raw & mask) | dom_sh;
    end
    lane_o = {word_i, lo_i};
  end

endmodule

// File: rtl/keccak_msg_padder.sv
// Packs a byte-counted 32-bit stream into 64-bit lanes and applies
// SHA3/SHAKE multi-rate padding with lane/block boundary flags.
module keccak_msg_padder
  import keccak_pad_pkg::*;
#(
  parameter int IN_W      = 32,
  parameter int LANE_W    = 64,
  parameter int MAX_LANES = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        cmode,
  input  logic [IN_W-1:0]   s_data,
  input  logic [2:0]        s_bytes,
  input  logic              s_last,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [LANE_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_first,
  output logic              m_last_lane,
  output logic              m_last_block,
  output logic              busy
);

  localparam int CW = $clog2(MAX_LANES);

  state_e state_q, state_d;

  logic [CW-1:0]     lane_cnt_q, lane_cnt_d;
  logic [CW-1:0]     rate_q, rate_d;
  logic [7:0]        dom_q, dom_d;
  logic              half_q, half_d;
  logic [IN_W-1:0]   lo_q, lo_d;
  logic [LANE_W-1:0] pad_q, pad_d;
  logic              first_q, first_d;
  logic              busy_q, busy_d;

  logic [LANE_W-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_first_q, m_first_d;
  logic              m_ll_q, m_ll_d;
  logic              m_lb_q, m_lb_d;

  logic              out_free;
  logic              s_fire;
  logic              at_end;
  logic              in_take;
  logic [7:0]        cur_dom;
  logic              ld;
  logic              ld_lb;
  logic              ld_end;
  logic [LANE_W-1:0] ld_lane;

  logic [LANE_W-1:0] pk_lane;
  logic [LANE_W-1:0] pk_pad;
  logic              pk_full;

  assign out_free = !m_valid_q || m_ready;
  assign in_take  = (state_q == IDLE) || (state_q == ABSORB);
  // A high-half word completes a lane, so it needs a free output slot.
  assign s_ready  = !rst && in_take && (!half_q || out_free);
  assign s_fire   = s_valid && s_ready;
  assign at_end   = (lane_cnt_q == rate_q - 1'b1);
  assign cur_dom  = (state_q == IDLE) ? domain_byte(cmode) : dom_q;

  lane_packer u_packer (
    .lo_i    (lo_q),
    .word_i  (s_data),
    .bytes_i (s_bytes),
    .hi_i    (half_q),
    .dom_i   (cur_dom),
    .lane_o  (pk_lane),
    .pad_o   (pk_pad),
    .full_o  (pk_full)
  );

  always_comb begin
    state_d    = state_q;
    lane_cnt_d = lane_cnt_q;
    rate_d     = rate_q;
    dom_d      = dom_q;
    half_d     = half_q;
    lo_d       = lo_q;
    pad_d      = pad_q;
    first_d    = first_q;
    busy_d     = busy_q;
    ld         = 1'b0;
    ld_lb      = 1'b0;
    ld_end     = 1'b0;
    ld_lane    = '0;

    if (m_valid_q && m_ready && m_ll_q && m_lb_q) begin
      busy_d = 1'b0;
    end

    case (state_q)
      IDLE, ABSORB: begin
        if (s_fire) begin
          if (state_q == IDLE) begin
            rate_d  = rate_lanes(cmode);
            dom_d   = cur_dom;
            first_d = 1'b1;
            busy_d  = 1'b1;
          end
          if (!half_q) begin
            if (s_last) begin
              pad_d   = pk_pad;
              state_d = PAD;
            end else begin
              lo_d    = s_data;
              half_d  = 1'b1;
              state_d = ABSORB;
            end
          end else begin
            half_d = 1'b0;
            if (!s_last || pk_full) begin
              ld      = 1'b1;
              ld_lane = pk_lane;
              // Last data lane of a block is not final when padding
              // spills into a whole extra block.
              ld_lb   = s_last && !at_end;
            end
            if (s_last) begin
              pad_d   = pk_pad;
              state_d = PAD;
            end
          end
        end
      end
      PAD: begin
        if (out_free) begin
          ld      = 1'b1;
          ld_lane = pad_q;
          ld_lb   = 1'b1;
          ld_end  = at_end;
          state_d = at_end ? IDLE : FILL;
        end
      end
      FILL: begin
        if (out_free) begin
          ld     = 1'b1;
          ld_lb  = 1'b1;
          ld_end = at_end;
          if (at_end) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q && !m_ready;
    m_first_d = m_first_q;
    m_ll_d    = m_ll_q;
    m_lb_d    = m_lb_q;
    if (ld) begin
      m_valid_d = 1'b1;
      m_data_d  = ld_lane;
      if (ld_end) begin
        m_data_d = ld_lane | {PAD_END, {(LANE_W-8){1'b0}}};
      end
      m_first_d = first_q;
      m_ll_d    = at_end;
      m_lb_d    = ld_lb;
    end
  end

  logic              first_nx;
  logic [CW-1:0]     cnt_nx;

  always_comb begin
    first_nx = first_d;
    cnt_nx   = lane_cnt_d;
    if (ld) begin
      first_nx = 1'b0;
      cnt_nx   = at_end ? '0 : lane_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lane_cnt_q <= '0;
      rate_q     <= '0;
      dom_q      <= '0;
      half_q     <= 1'b0;
      lo_q       <= '0;
      pad_q      <= '0;
      first_q    <= 1'b0;
      busy_q     <= 1'b0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_first_q  <= 1'b0;
      m_ll_q     <= 1'b0;
      m_lb_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_cnt_q <= cnt_nx;
      rate_q     <= rate_d;
      dom_q      <= dom_d;
      half_q     <= half_d;
      lo_q       <= lo_d;
      pad_q      <= pad_d;
      first_q    <= first_nx;
      busy_q     <= busy_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_first_q  <= m_first_d;
      m_ll_q     <= m_ll_d;
      m_lb_q     <= m_lb_d;
    end
  end

  assign m_data       = m_data_q;
  assign m_valid      = m_valid_q;
  assign m_first      = m_first_q;
  assign m_last_lane  = m_ll_q;
  assign m_last_block = m_lb_q;
  assign busy         = busy_q;

endmodule
